rom_rd_client: RTL and testbench
================================

ROM_RD_CLIENT -- requirements
Module: rom_rd_client

Interface
REQ-001 clk  input  1  SDRAM clock; all logic on its rising edge.
REQ-002 init_n  input  1  Asynchronous active-low reset.
REQ-003 cpu_req  input  1  Single-cycle read strobe; sampled only when cpu_busy=0.
REQ-004 cpu_a  input  23  Word address [23:1]; sampled with cpu_req.
REQ-005 cpu_busy  output  1  High from accepted cpu_req until cpu_ack, inclusive of the accept cycle's following cycle.
REQ-006 cpu_ack  output  1  One-cycle pulse; cpu_q valid in the same cycle.
REQ-007 cpu_q  output  16  Read data; holds until next cpu_ack.
REQ-008 inv  input  1  One-cycle pulse: discard prefetched/in-flight prefetch data (ROM rewrite).
REQ-009 romrd_req  output  1  Toggle request to SDRAM controller; registered.
REQ-010 romrd_ack  input  1  Toggle acknowledge; romrd_q valid when romrd_ack becomes equal to romrd_req.
REQ-011 romrd_a  output  23  Word address of the outstanding SDRAM read; stable while romrd_req!=romrd_ack.
REQ-012 romrd_q  input  16  SDRAM read data.

Function
REQ-013 Handshake: the block SHALL start an SDRAM read only by inverting romrd_req while romrd_req==romrd_ack; at most one read outstanding.
REQ-014 Completion: a read SHALL be complete on the first cycle romrd_ack==romrd_req after issue; romrd_q SHALL be captured in that cycle.
REQ-015 States: SYNC, IDLE, DEMAND, PREFETCH, WAIT_PF.
REQ-016 SYNC: first cycle after reset; romrd_req <= romrd_ack; -> IDLE.
REQ-017 IDLE + cpu_req: on prefetch hit (pf_valid && cpu_a==pf_a), cpu_q <= pf_data, cpu_ack next cycle, issue prefetch of cpu_a+1 -> PREFETCH; on miss, issue demand read of cpu_a -> DEMAND.
REQ-018 DEMAND completion: cpu_q <= romrd_q, cpu_ack pulse the following cycle; then issue prefetch of address+1 -> PREFETCH.
REQ-019 PREFETCH completion: pf_data <= romrd_q, pf_valid <= 1 unless discarded; -> IDLE.
REQ-020 cpu_req during PREFETCH: latch cpu_a -> WAIT_PF; on completion, match -> hit path of REQ-017; mismatch -> drop data, issue demand -> DEMAND.
REQ-021 Latency: miss = cpu_ack 1 cycle after the romrd_ack completion cycle; hit from IDLE = cpu_ack 1 cycle after cpu_req.
REQ-022 Address arithmetic: prefetch address = (address+1) mod 2^23; 23'h7FFFFF wraps to 0.
REQ-023 inv: clears pf_valid immediately; if a prefetch is in flight its data SHALL be discarded on completion; inv coinciding with a hit lookup SHALL force a miss.
REQ-024 cpu_req while cpu_busy=1 SHALL be ignored.
REQ-025 romrd_a SHALL change only in the cycle romrd_req toggles.

Reset
REQ-026 While init_n=0: state SYNC, romrd_req=0, romrd_a=0, cpu_ack=0, cpu_busy=0, cpu_q=0, pf_valid=0, pf_data=0.
REQ-027 Reset mid-transaction SHALL abandon the transaction without a cpu_ack; SYNC re-aligns toggle parity on release.

Configuration
REQ-028 Macro ROM_RD_PREFETCH_EN defined: prefetch per REQ-017..023.
REQ-029 Macro undefined: no PREFETCH/WAIT_PF states, pf_valid tied 0, every cpu_req is a demand read, DEMAND -> IDLE on completion, inv ignored.

Verification
REQ-030 Reset release with romrd_ack=1 -> romrd_req=1 after SYNC; no read issued.
REQ-031 cpu_req a=0x000100, ack after 9 cycles, romrd_q=0xBEEF -> cpu_q=0xBEEF, cpu_ack 1 cycle later; then romrd_a=0x000101 toggled.
REQ-032 Prefetch of 0x000101 returns 0x1234, then cpu_req a=0x000101 -> cpu_ack next cycle, cpu_q=0x1234, romrd_a=0x000102.
REQ-033 cpu_req a=0x000200 during in-flight prefetch of 0x000101 -> wait, discard, demand 0x000200; exactly one cpu_ack.
REQ-034 Demand a=0x7FFFFF -> prefetch romrd_a=0x000000; inv before completion -> subsequent cpu_req a=0 is a miss.
REQ-035 ROM_RD_PREFETCH_EN undefined: two sequential reads 0x10,0x11 -> two demand toggles, no extra toggle.

Source files
------------

// File: rtl/rom_rd_client.sv
// rom_rd_client: CPU-side ROM read client in front of a toggle-handshake SDRAM read port,
//   with an optional single-word sequential prefetch buffer.
// Latency: miss -> cpu_ack one cycle after the SDRAM completion cycle; prefetch hit -> cpu_ack one cycle after cpu_req.
// Backpressure: cpu_busy is high from the cycle after an accepted cpu_req through its cpu_ack cycle;
//   cpu_req is ignored while busy. At most one SDRAM read is outstanding at any time.
//
// Ports:
//   clk, init_n           - SDRAM clock, asynchronous active-low reset
//   cpu_req, cpu_a        - single-cycle read strobe and word address (sampled when cpu_busy=0)
//   cpu_busy, cpu_ack     - busy level and one-cycle completion pulse
//   cpu_q                 - read data, held until the next cpu_ack
//   inv                   - one-cycle pulse discarding prefetched / in-flight prefetch data
//   romrd_req, romrd_ack  - toggle request / toggle acknowledge to the SDRAM controller
//   romrd_a, romrd_q      - SDRAM read address (changes only when romrd_req toggles) and data
//
// Build option: define ROM_RD_PREFETCH_EN to enable the prefetch buffer. Without it every cpu_req
// is a demand read and inv is ignored.
module rom_rd_client (
  input  logic        clk,
  input  logic        init_n,
  input  logic        cpu_req,
  input  logic [22:0] cpu_a,
  output logic        cpu_busy,
  output logic        cpu_ack,
  output logic [15:0] cpu_q,
  input  logic        inv,
  output logic        romrd_req,
  input  logic        romrd_ack,
  output logic [22:0] romrd_a,
  input  logic [15:0] romrd_q
);

`ifdef ROM_RD_PREFETCH_EN
  typedef enum logic [2:0] {SYNC, IDLE, DEMAND, PREFETCH, WAIT_PF} state_e;
`else
  typedef enum logic [1:0] {SYNC, IDLE, DEMAND} state_e;
`endif

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [22:0] ra_q, ra_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic [15:0] cq_q, cq_d;

  logic        rd_done;
  logic        accept;

  // The outstanding read is complete as soon as the acknowledge parity catches up with ours.
  assign rd_done = (romrd_ack == req_q);
  assign accept  = cpu_req & ~busy_q;

`ifdef ROM_RD_PREFETCH_EN
  logic        pf_valid_q, pfv_d;
  logic [15:0] pf_data_q, pfd_d;
  logic [22:0] pf_a_q, pfa_d;
  logic [22:0] pend_a_q, pend_d;
  logic        disc_q, disc_d;

  // Shared hit/miss lookup. From IDLE it compares against the stored prefetch buffer; on a prefetch
  // completion (PREFETCH with a simultaneous cpu_req, or WAIT_PF) it compares against the word
  // arriving from SDRAM right now, so no extra cycle is spent parking it in the buffer.
  logic        lk_go;
  logic        lk_ok;
  logic        lk_hit;
  logic [22:0] lk_a;
  logic [22:0] lk_tag;
  logic [15:0] lk_dat;

  assign lk_a   = (state_q == WAIT_PF) ? pend_a_q : cpu_a;
  assign lk_ok  = (state_q == IDLE) ? pf_valid_q : ~disc_q;
  assign lk_tag = (state_q == IDLE) ? pf_a_q : ra_q;
  assign lk_dat = (state_q == IDLE) ? pf_data_q : romrd_q;
  // inv in the lookup cycle means the candidate word may be stale: force a miss.
  assign lk_hit = lk_ok & ~inv & (lk_a == lk_tag);
`else
  logic unused_inv;
  assign unused_inv = inv;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ra_d    = ra_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    cq_d    = cq_q;
`ifdef ROM_RD_PREFETCH_EN
    pfv_d   = pf_valid_q & ~inv;
    pfd_d   = pf_data_q;
    pfa_d   = pf_a_q;
    pend_d  = pend_a_q;
    disc_d  = disc_q;
    lk_go   = 1'b0;
`endif

    // Busy covers the ack cycle itself and drops on the cycle after it.
    if (ack_q) begin
      busy_d = 1'b0;
    end

    case (state_q)
      // Copy the controller's acknowledge parity so no read is issued by the reset itself.
      // A cpu_req arriving here is dropped; the CPU is not yet told we are busy.
      SYNC: begin
        req_d   = romrd_ack;
        state_d = IDLE;
      end

      IDLE: begin
        if (accept) begin
          busy_d = 1'b1;
`ifdef ROM_RD_PREFETCH_EN
          lk_go  = 1'b1;
`else
          req_d   = ~req_q;
          ra_d    = cpu_a;
          state_d = DEMAND;
`endif
        end
      end

      DEMAND: begin
        if (rd_done) begin
          cq_d  = romrd_q;
          ack_d = 1'b1;
`ifdef ROM_RD_PREFETCH_EN
          // Completion frees the port this cycle, so the next-word prefetch goes out immediately.
          req_d   = ~req_q;
          ra_d    = ra_q + 23'd1;
          pfv_d   = 1'b0;
          disc_d  = inv;
          state_d = PREFETCH;
`else
          state_d = IDLE;
`endif
        end
      end

`ifdef ROM_RD_PREFETCH_EN
      PREFETCH: begin
        if (accept) begin
          busy_d = 1'b1;
          pend_d = cpu_a;
        end
        if (rd_done) begin
          disc_d = 1'b0;
          if (accept) begin
            lk_go = 1'b1;
          end else begin
            state_d = IDLE;
            if (!(disc_q | inv)) begin
              pfv_d = 1'b1;
              pfd_d = romrd_q;
              pfa_d = ra_q;
            end
          end
        end else begin
          if (inv) begin
            disc_d = 1'b1;
          end
          if (accept) begin
            state_d = WAIT_PF;
          end
        end
      end

      WAIT_PF: begin
        if (rd_done) begin
          lk_go = 1'b1;
        end else if (inv) begin
          disc_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = SYNC;
      end
    endcase

`ifdef ROM_RD_PREFETCH_EN
    // Every lookup issues exactly one read: the next prefetch on a hit, the demand read on a miss.
    // Either way the buffer contents are consumed or superseded.
    if (lk_go) begin
      pfv_d  = 1'b0;
      disc_d = 1'b0;
      req_d  = ~req_q;
      if (lk_hit) begin
        cq_d    = lk_dat;
        ack_d   = 1'b1;
        ra_d    = lk_a + 23'd1;
        state_d = PREFETCH;
      end else begin
        ra_d    = lk_a;
        state_d = DEMAND;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= SYNC;
      req_q   <= 1'b0;
      ra_q    <= 23'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      cq_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ra_q    <= ra_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cq_q    <= cq_d;
    end
  end

`ifdef ROM_RD_PREFETCH_EN
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      pf_valid_q <= 1'b0;
      pf_data_q  <= 16'd0;
      pf_a_q     <= 23'd0;
      pend_a_q   <= 23'd0;
      disc_q     <= 1'b0;
    end else begin
      pf_valid_q <= pfv_d;
      pf_data_q  <= pfd_d;
      pf_a_q     <= pfa_d;
      pend_a_q   <= pend_d;
      disc_q     <= disc_d;
    end
  end
`endif

  assign cpu_busy  = busy_q;
  assign cpu_ack   = ack_q;
  assign cpu_q     = cq_q;
  assign romrd_req = req_q;
  assign romrd_a   = ra_q;

endmodule

// File: tb/tb_rom_rd_client.sv
// tb_rom_rd_client: directed-vector bench for rom_rd_client with a toggle-handshake SDRAM responder,
// a scoreboard of expected cpu_q values / SDRAM read addresses, and a negedge monitor that checks them.
module tb_rom_rd_client;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [22:0] cpu_a = 23'd0;
  logic        cpu_busy;
  logic        cpu_ack;
  logic [15:0] cpu_q;
  logic        inv = 1'b0;
  logic        romrd_req;
  logic        romrd_ack = 1'b0;
  logic [22:0] romrd_a;
  logic [15:0] romrd_q = 16'd0;

  rom_rd_client dut (
    .clk       (clk),
    .init_n    (init_n),
    .cpu_req   (cpu_req),
    .cpu_a     (cpu_a),
    .cpu_busy  (cpu_busy),
    .cpu_ack   (cpu_ack),
    .cpu_q     (cpu_q),
    .inv       (inv),
    .romrd_req (romrd_req),
    .romrd_ack (romrd_ack),
    .romrd_a   (romrd_a),
    .romrd_q   (romrd_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    bit          hit;
  } exp_t;

  exp_t        exp_q[$];
  logic [22:0] exp_rd[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int req_cyc = 0;
  int done_cyc = 0;
  int ack_cnt = 0;
  int n_issue = 0;
  int n_sync = 0;
  int lat = 9;
  logic ack_rst_lvl = 1'b1;

  int exp_iss;
  int exp_acks;
  logic [15:0] last_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [22:0] a);
    case (a)
      23'h000100: return 16'hBEEF;
      23'h000101: return 16'h1234;
      23'h000102: return 16'h5678;
      23'h000200: return 16'hCAFE;
      23'h7FFFFF: return 16'h7777;
      23'h000000: return 16'h0F0F;
      23'h000001: return 16'h0101;
      23'h000010: return 16'h1010;
      23'h000011: return 16'h1111;
      default:    return 16'hDEAD;
    endcase
  endfunction

  // SDRAM controller model: acknowledges a new request 'lat' cycles after it appears.
  initial begin
    int cnt;
    bit act;
    logic [22:0] a;
    act = 0;
    cnt = 0;
    a = 23'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!init_n) begin
        act = 0;
        romrd_ack = ack_rst_lvl;
      end else if (act) begin
        if (cnt <= 1) begin
          romrd_q   = mem_rd(a);
          romrd_ack = ~romrd_ack;
          done_cyc  = cyc;
          act = 0;
        end else begin
          cnt--;
        end
      end else if (romrd_req != romrd_ack) begin
        act = 1;
        a   = romrd_a;
        cnt = lat;
      end
    end
  end

  // Monitor: checks every cpu_ack and every read issue against the scoreboard.
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [22:0] prev_a = 23'd0;

  always @(negedge clk) begin
    if (init_n) begin
      if (cpu_ack) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_cpu_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cpu_q", {16'd0, cpu_q}, {16'd0, e.q});
          chk(e.hit ? "hit_latency" : "miss_latency", cyc, (e.hit ? req_cyc : done_cyc) + 1);
        end
      end
      if (romrd_req != prev_req) begin
        if (prev_req == prev_ack) begin
          n_issue++;
          if (exp_rd.size() == 0) begin
            chk("unexpected_read_issue", {9'd0, romrd_a}, 32'hFFFFFFFF);
          end else begin
            logic [22:0] ea;
            ea = exp_rd.pop_front();
            chk("romrd_a", {9'd0, romrd_a}, {9'd0, ea});
          end
        end else begin
          n_sync++;
        end
      end else if (romrd_a != prev_a) begin
        chk("romrd_a_stable", {9'd0, romrd_a}, {9'd0, prev_a});
      end
    end
    prev_req = romrd_req;
    prev_ack = romrd_ack;
    prev_a   = romrd_a;
  end

  task automatic do_reset(input logic lvl);
    ack_rst_lvl = lvl;
    init_n  = 1'b0;
    cpu_req = 1'b0;
    inv     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_busy", {31'd0, cpu_busy}, 32'd0);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_cpu_q", {16'd0, cpu_q}, 32'd0);
    chk("rst_romrd_req", {31'd0, romrd_req}, 32'd0);
    chk("rst_romrd_a", {9'd0, romrd_a}, 32'd0);
    init_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+#1; returns one cycle after the accept edge.
  task automatic cpu_read(input logic [22:0] a, input logic [15:0] d, input bit hit);
    int n;
    exp_t e;
    n = 0;
    while (cpu_busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cpu_busy) begin
      chk("busy_timeout", 32'd1, 32'd0);
    end
    e.q = d;
    e.hit = hit;
    exp_q.push_back(e);
    cpu_req = 1'b1;
    cpu_a   = a;
    req_cyc = cyc;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    chk("busy_after_accept", {31'd0, cpu_busy}, 32'd1);
  endtask

  task automatic wait_acks(input int target);
    int n;
    n = 0;
    while (ack_cnt < target && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ack_cnt < target) begin
      chk("ack_timeout", ack_cnt, target);
    end
  endtask

  task automatic wait_rd_idle();
    int n;
    n = 0;
    while (romrd_req != romrd_ack && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (romrd_req != romrd_ack) begin
      chk("rd_idle_timeout", {31'd0, romrd_req}, {31'd0, romrd_ack});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with the controller's ack parity at 1: SYNC must align, not issue.
    do_reset(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("sync_romrd_req", {31'd0, romrd_req}, 32'd1);
    chk("sync_no_issue", n_issue, 0);
    chk("sync_aligned", n_sync, 1);

    // Demand miss with a 9-cycle SDRAM latency; a cpu_req while busy must be ignored.
    lat = 9;
    exp_rd.push_back(23'h000100);
`ifdef ROM_RD_PREFETCH_EN
    exp_rd.push_back(23'h000101);
`endif
    cpu_read(23'h000100, 16'hBEEF, 0);
    cpu_a   = 23'h003333;
    cpu_req = 1'b1;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    wait_acks(1);

`ifdef ROM_RD_PREFETCH_EN
    wait_rd_idle();
    // Prefetch hit: ack one cycle after cpu_req, next prefetch 0x102.
    exp_rd.push_back(23'h000102);
    cpu_read(23'h000101, 16'h1234, 1);
    wait_acks(2);
    // Request for another address while the 0x102 prefetch is in flight.
    exp_rd.push_back(23'h000200);
    exp_rd.push_back(23'h000201);
    cpu_read(23'h000200, 16'hCAFE, 0);
    wait_acks(3);
    wait_rd_idle();
    // Wrap to 0, then invalidate the in-flight prefetch: address 0 must miss.
    exp_rd.push_back(23'h7FFFFF);
    exp_rd.push_back(23'h000000);
    cpu_read(23'h7FFFFF, 16'h7777, 0);
    wait_acks(4);
    inv = 1'b1;
    @(posedge clk);
    #1;
    inv = 1'b0;
    wait_rd_idle();
    exp_rd.push_back(23'h000000);
    exp_rd.push_back(23'h000001);
    cpu_read(23'h000000, 16'h0F0F, 0);
    wait_acks(5);
    wait_rd_idle();
    // Clean prefetch of 0x1 now valid: hit from IDLE.
    exp_rd.push_back(23'h000002);
    cpu_read(23'h000001, 16'h0101, 1);
    wait_acks(6);
    wait_rd_idle();
    last_q   = 16'h0101;
    exp_iss  = 10;
    exp_acks = 6;
`else
    // Two sequential reads: two demand toggles only.
    lat = 3;
    exp_rd.push_back(23'h000010);
    cpu_read(23'h000010, 16'h1010, 0);
    wait_acks(2);
    lat = 1;
    exp_rd.push_back(23'h000011);
    cpu_read(23'h000011, 16'h1111, 0);
    wait_acks(3);
    lat = 5;
    exp_rd.push_back(23'h7FFFFF);
    cpu_read(23'h7FFFFF, 16'h7777, 0);
    wait_acks(4);
    inv = 1'b1;
    @(posedge clk);
    #1;
    inv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    last_q   = 16'h7777;
    exp_iss  = 4;
    exp_acks = 4;
`endif

    // cpu_q holds its last value; no stray reads or acks so far.
    repeat (5) @(posedge clk);
    #1;
    chk("cpu_q_hold", {16'd0, cpu_q}, {16'd0, last_q});
    chk("idle_not_busy", {31'd0, cpu_busy}, 32'd0);
    chk("issue_count", n_issue, exp_iss);
    chk("ack_count", ack_cnt, exp_acks);

    // Reset in the middle of a demand read: no ack, then a clean read afterwards.
    lat = 20;
    exp_rd.push_back(23'h000055);
    cpu_read(23'h000055, 16'hDEAD, 0);
    repeat (3) @(posedge clk);
    #1;
    do_reset(1'b0);
    exp_q.delete();
    exp_rd.delete();
    repeat (25) @(posedge clk);
    #1;
    chk("no_ack_after_abort", ack_cnt, exp_acks);

    lat = 2;
    exp_rd.push_back(23'h000100);
`ifdef ROM_RD_PREFETCH_EN
    exp_rd.push_back(23'h000101);
`endif
    cpu_read(23'h000100, 16'hBEEF, 0);
    wait_acks(exp_acks + 1);
`ifdef ROM_RD_PREFETCH_EN
    wait_rd_idle();
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("exp_ack_drained", exp_q.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
